nibble_serial_add_sched: RTL and testbench
==========================================

// Module: nibble_serial_add_sched
// PURPOSE
//  Shares one 4-bit add slice (a+b+cin -> 4-bit sum, carry out) between NREQ requesters.
//  Each request is a WIDTH-bit add, executed one nibble per cycle, LSB nibble first.
//  Round-robin arbitration; valid/ready handshake on request and result sides.
//  Sits between client blocks needing occasional wide adds and the nibble adder datapath.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; multiple of 4, >= 4; N = WIDTH/4 nibbles
//  NREQ   2   number of requesters, 1..8; IDW = max(1, clog2(NREQ))
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       per-requester request valid
//  req_ready  out  NREQ       per-requester accept; one-hot or zero
//  req_a      in   NREQ*WIDTH packed operand A; requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH packed operand B, same packing
//  req_cin    in   NREQ       per-requester carry in
//  res_valid  out  1          result valid
//  res_ready  in   1          result consumer accept
//  res_id     out  IDW        index of requester that owns the result
//  res_sum    out  WIDTH      A+B+cin, low WIDTH bits
//  res_cout   out  1          carry out of MSB nibble
//  busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0,
//   busy=0, req_ready=0, last_grant=NREQ-1 (requester 0 wins first), nib_cnt=0.
//  FSM states: IDLE -> ADD -> DONE -> IDLE.
//  IDLE: if any req_valid, winner = first set req_valid scanning last_grant+1, +2, ...
//   (mod NREQ); req_ready[winner]=1 combinationally (IDLE & grant), for this cycle only.
//   Handshake completes on that edge: capture a, b, cin, winner into op regs.
//   carry_reg=cin, nib_cnt=0, last_grant=winner -> ADD. No req_valid: stay IDLE.
//  ADD: slice inputs = op_a/op_b nibble[nib_cnt] and carry_reg. Each cycle writes
//   sum_reg nibble[nib_cnt] and updates carry_reg from slice carry out; nib_cnt++.
//   After nibble N-1 -> DONE. WIDTH=4 gives exactly one ADD cycle.
//  DONE: res_valid=1. res_sum, res_cout and res_id are registered and stable until
//   the handshake. res_valid & res_ready on an edge -> IDLE, res_valid=0 next cycle.
//   res_ready low holds DONE indefinitely.
//  Latency: accept edge = cycle 0. ADD runs cycles 1..N. res_valid rises in cycle N+1.
//   Minimum issue interval is N+2 cycles. No new request is accepted outside IDLE.
//  req_ready is 0 in ADD and DONE regardless of req_valid.
//  Requesters hold valid and operands until their ready. Arbitration is re-evaluated
//   every IDLE cycle, so a withdrawn valid is simply not granted.
//  Captured operands are isolated: changes on req_a/req_b after accept do not affect
//   the result.
//  Arithmetic: modulo 2^WIDTH. Carry ripples between nibbles through carry_reg only.
//   res_cout = final carry_reg.
//  NREQ=1: the arbiter degenerates to a pass-through. res_id is always 0.
//  Reset mid-operation (ADD or DONE): the operation is abandoned with no res_valid.
//   The requester is not re-served unless it raises valid again after reset.
//  res_sum/res_id/res_cout hold the last result after leaving DONE; they are
//   meaningful only while res_valid=1.
// TESTING
//  Defaults WIDTH=16, NREQ=2, res_ready=1 unless stated.
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, busy=0, req_ready=0.
//  2 Single op: req0 a=0x1234 b=0x0FCD cin=0 -> req_ready=01 for 1 cycle; res_valid in
//    cycle 5; res_sum=0x2201, res_cout=0, res_id=0; res_valid low in cycle 6.
//  3 Full ripple: req1 a=0xFFFF b=0x0000 cin=1 -> res_sum=0x0000, res_cout=1, res_id=1.
//    Then a=0xFFFF b=0xFFFF cin=1 -> res_sum=0xFFFF, res_cout=1.
//  4 Round-robin: both req_valid held high with distinct operands -> grant order
//    0,1,0,1. Each grant is 6 cycles apart; every res_id matches its operands.
//  5 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid stays 1, outputs
//    stable, req_ready=0 throughout. res_ready=1 -> IDLE next cycle, new grant follows.
//  6 Reset in ADD: rst_n pulse at cycle 2 of an op -> no res_valid. Then req0 wins the
//    next arbitration with both requesters valid.

Source files
------------

// File: rtl/nibble_serial_add_sched.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_sched
//
// Purpose:
//   Shares a single 4-bit add slice (a + b + cin -> 4-bit sum, carry out)
//   between NREQ requesters. Each accepted request is a WIDTH-bit add that is
//   executed one nibble per cycle, least-significant nibble first, with the
//   carry rippling between nibbles through a register. Requesters are served
//   round-robin; both the request and the result side use valid/ready.
//
// Ports:
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        per-requester accept (one-hot or zero)
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   req_cin    in   NREQ        per-requester carry in
//   res_valid  out  1           result valid
//   res_ready  in   1           result consumer accept
//   res_id     out  IDW         index of the requester owning the result
//   res_sum    out  WIDTH       A + B + cin, low WIDTH bits
//   res_cout   out  1           carry out of the most significant nibble
//   busy       out  1           high whenever the scheduler is not idle
// ----------------------------------------------------------------------------
module nibble_serial_add_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2,
    localparam int N    = WIDTH / 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic [WIDTH-1:0]        res_sum,
    output logic                    res_cout,
    output logic                    busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_res_valid;
    logic [CW-1:0]    r_nib_cnt;

    logic [WIDTH-1:0] w_a [NREQ];
    logic [WIDTH-1:0] w_b [NREQ];
    logic             w_win_vld [NREQ];
    logic [IDW-1:0]   w_win_idx [NREQ];
    logic             w_gnt_valid;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_ready;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [4:0]       w_slice;
    logic [CW+1:0]    w_nib_base;

    // Unpack the flat operand buses into per-requester words.
    // For every possible previous winner gi, precompute who would win next:
    // scan gi+1, gi+2, ... (mod NREQ). All indices are elaboration constants,
    // so the run-time choice is a plain mux on r_last_grant.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign w_a[gi] = req_a[gi*WIDTH +: WIDTH];
        assign w_b[gi] = req_b[gi*WIDTH +: WIDTH];

        always_comb begin
            w_win_vld[gi] = 1'b0;
            w_win_idx[gi] = '0;
            // Descending scan: the nearest valid requester is assigned last
            // and therefore wins.
            for (int k = NREQ; k >= 1; k--) begin
                if (req_valid[(gi + k) % NREQ]) begin
                    w_win_vld[gi] = 1'b1;
                    w_win_idx[gi] = IDW'((gi + k) % NREQ);
                end
            end
        end
    end

    assign w_gnt_valid = w_win_vld[r_last_grant];
    assign w_gnt_idx   = w_win_idx[r_last_grant];

    // Accept is combinational and only offered while idle; held low during
    // reset so a pending valid never sees a spurious accept.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_gnt_valid) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end
    assign req_ready = w_ready;

    // Shared 4-bit add slice operating on the current nibble.
    assign w_nib_base = {r_nib_cnt, 2'b00};
    assign w_nib_a    = r_op_a[w_nib_base +: 4];
    assign w_nib_b    = r_op_b[w_nib_base +: 4];
    assign w_slice    = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cout       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_nib_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_op_a       <= w_a[w_gnt_idx];
                        r_op_b       <= w_b[w_gnt_idx];
                        r_carry      <= req_cin[w_gnt_idx];
                        r_id         <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_nib_cnt    <= '0;
                        r_state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum[w_nib_base +: 4] <= w_slice[3:0];
                    r_carry                <= w_slice[4];
                    if (r_nib_cnt == CW'(N - 1)) begin
                        r_cout      <= w_slice[4];
                        r_res_valid <= 1'b1;
                        r_nib_cnt   <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_nib_cnt <= r_nib_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_id;
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_nibble_serial_add_sched.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_add_sched
//
// Self-checking bench for nibble_serial_add_sched (WIDTH=16, NREQ=2).
// Accepted requests push their expected result onto a queue; every result
// handshake pops and compares. Directed sequences cover reset, latency,
// carry ripple, round-robin ordering, backpressure and reset mid-operation.
// ----------------------------------------------------------------------------
module tb_nibble_serial_add_sched;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic                  busy;

    int   n_checks;
    int   n_errors;
    int   cyc_cnt;
    exp_t sb_q[$];

    nibble_serial_add_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain WIDTH+1 bit addition.
    function automatic exp_t model(input int id, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin);
        exp_t e;
        logic [WIDTH:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.id   = IDW'(id);
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        return e;
    endfunction

    // Monitor: request handshakes push, result handshakes pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back(model(i, req_a[i*WIDTH +: WIDTH],
                                         req_b[i*WIDTH +: WIDTH], req_cin[i]));
                    $display("req  id=%0d a=%h b=%h cin=%0d", i,
                             req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_cin[i]);
                end
            end
            if (res_valid && res_ready) begin
                $display("res  id=%0d sum=%h cout=%0d", res_id, res_sum, res_cout);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("res_id",   32'(res_id),   32'(e.id));
                    chk("res_sum",  32'(res_sum),  32'(e.sum));
                    chk("res_cout", 32'(res_cout), 32'(e.cout));
                end
            end
        end
    end

    task automatic drive_req(input int id, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic cin);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_cin[id]              = cin;
        req_valid[id]            = 1'b1;
    endtask

    // Wait (bounded) for the accept of requester id, then drop its valid.
    task automatic wait_accept(input int id);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        chk("accept_timeout", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for a result handshake to be sampled, then step past it.
    task automatic wait_result();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (res_valid && res_ready) seen = 1'b1;
        end
        chk("result_timeout", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input int id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin);
        @(posedge clk); #1;
        drive_req(id, a, b, cin);
        wait_accept(id);
        wait_result();
    endtask

    // Start an op, assert reset mid-cycle during its second ADD cycle, check
    // outputs clear immediately and that no result ever appears.
    task automatic abort_op(input int id, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        @(posedge clk); #1;
        drive_req(id, a, b, 1'b0);
        wait_accept(id);          // returns in ADD cycle 1
        @(posedge clk); #3;       // ADD cycle 2
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum",   32'(res_sum),   32'd0);
        chk("rst_res_cout",  32'(res_cout),  32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_res_valid", 32'(res_valid), 32'd0);
            chk("abort_idle",         32'(busy),      32'd0);
        end
    endtask

    initial begin
        int ngr;
        int last_cyc;
        int gcnt[NREQ];
        int g;
        logic [WIDTH-1:0] bp_a, bp_b;
        exp_t bp_e;

        n_checks  = 0;
        n_errors  = 0;
        cyc_cnt   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("init_busy",      32'(busy),      32'd0);
        chk("init_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op with exact latency.
        @(posedge clk); #1;
        drive_req(0, 16'h1234, 16'h0FCD, 1'b0);
        @(negedge clk);
        chk("t2_ready_c0", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t2_res_valid", 32'(res_valid), 32'(c == 5));
            chk("t2_ready_zero", 32'(req_ready), 32'd0);
            chk("t2_busy", 32'(busy), 32'd1);
            if (c == 5) chk("t2_sum", 32'(res_sum), 32'h2201);
        end
        @(negedge clk);
        chk("t2_res_valid_c6", 32'(res_valid), 32'd0);

        // Full carry ripple.
        run_op(1, 16'hFFFF, 16'h0000, 1'b1);
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b1);

        // Reset mid-op (requester 1) with all outputs checked for clear.
        abort_op(1, 16'h5555, 16'h1111);

        // Reset mid-op of requester 0, then both valid: requester 0 must win
        // because reset restores the round-robin pointer. Then run 0,1,0,1.
        abort_op(0, 16'h0A0A, 16'h0505);
        @(posedge clk); #1;
        drive_req(0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        drive_req(1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        ngr      = 0;
        last_cyc = 0;
        gcnt[0]  = 0;
        gcnt[1]  = 0;
        for (int c = 0; c < 80 && ngr < 4; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                chk("rr_order", 32'(g), 32'(ngr % 2));
                if (ngr > 0) chk("rr_interval", 32'(cyc_cnt - last_cyc), 32'd6);
                last_cyc = cyc_cnt;
                ngr++;
                gcnt[g]++;
                @(posedge clk); #1;
                if (gcnt[g] == 2) req_valid[g] = 1'b0;
                else drive_req(g, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            end
        end
        chk("rr_grants", 32'(ngr), 32'd4);
        wait_result();

        // Backpressure: hold DONE for 10 cycles with requester 1 waiting.
        bp_a = 16'hBEEF;
        bp_b = 16'h4321;
        bp_e = model(0, bp_a, bp_b, 1'b1);
        res_ready = 1'b0;
        drive_req(0, bp_a, bp_b, 1'b1);
        wait_accept(0);
        drive_req(1, 16'h7777, 16'h8889, 1'b0);
        for (int c = 0; c < 40 && !res_valid; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_sum",   32'(res_sum),   32'(bp_e.sum));
            chk("bp_res_cout",  32'(res_cout),  32'(bp_e.cout));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);           // result handshake sampled here
        chk("bp_last_valid", 32'(res_valid), 32'd1);
        @(negedge clk);           // back in IDLE: requester 1 granted
        chk("bp_res_valid_low", 32'(res_valid), 32'd0);
        chk("bp_new_grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_result();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
